// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode bytes from a serial pin bus, launches one ALU operation,
// and returns the result (or a timeout error) through a valid/ready handshake.
module alu_operand_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    output logic       alu_start,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    input  logic       alu_done,
    output logic [7:0] out_data,
    output logic [3:0] out_flags,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    // state   | meaning
    // LOAD_A  | idle, waiting for operand A byte
    // LOAD_B  | waiting for operand B byte
    // LOAD_OP | waiting for opcode byte
    // ISSUE   | alu_start pulse, timeout counter cleared
    // WAIT    | waiting for alu_done or timeout
    // OUT     | result presented until out_ready
    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_OP,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] count;

    // Handshake flags are registered alongside each transition so they track state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD_A;
            count     <= 8'h00;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_op    <= 4'h0;
            alu_start <= 1'b0;
            out_data  <= 8'h00;
            out_flags <= 4'h0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (in_valid) begin
                        alu_a <= in_data;
                        busy  <= 1'b1;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        alu_b <= in_data;
                        state <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (in_valid) begin
                        alu_op    <= in_data[3:0];
                        in_ready  <= 1'b0;
                        alu_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_start <= 1'b0;
                    count     <= 8'h00;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A completion on the final allowed cycle beats the timeout.
                    if (alu_done) begin
                        out_data  <= alu_result;
                        out_flags <= alu_flags;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (count == LAST_WAIT) begin
                        out_data  <= 8'h00;
                        out_flags <= 4'h0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        count <= count + 8'h01;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= LOAD_A;
                    end
                end
                default: begin
                    alu_start <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer: byte driver, ALU responder model
// and result monitor run independently against queues of expected responses.
module tb_alu_operand_sequencer;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic       alu_start;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic       alu_done;
    logic [7:0] out_data;
    logic [3:0] out_flags;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    alu_operand_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_done(alu_done),
        .out_data(out_data), .out_flags(out_flags), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        int         start_cyc;
    } ops_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] flags;
        logic       err;
        int         first_cyc;
    } res_t;

    ops_t       exp_ops[$];
    res_t       exp_res[$];
    logic [7:0] stim_q[$];
    logic [7:0] part[$];
    int         lat_q[$];
    logic [11:0] res_q[$];
    int         hold_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_bytes  = 0;
    int n_done   = 0;
    int gap_pct  = 0;
    int alu_cnt  = 0;
    bit ready_always = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Byte driver and operand-triple model
    initial begin : driver
        bit took, rst_seen;
        ops_t o;
        in_valid = 1'b0;
        in_data  = 8'h00;
        forever begin
            @(negedge clk);
            took = 1'b0;
            rst_seen = rst;
            if (rst) begin
                part.delete();
                exp_ops.delete();
            end else if (in_valid && in_ready) begin
                took = 1'b1;
                n_bytes++;
                part.push_back(in_data);
                if (part.size() == 3) begin
                    o.a = part[0];
                    o.b = part[1];
                    o.op = part[2][3:0];
                    o.start_cyc = cyc + 1;
                    exp_ops.push_back(o);
                    part.delete();
                end
            end
            @(posedge clk);
            #1;
            if (rst_seen || took) in_valid = 1'b0;
            if (!in_valid && stim_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = stim_q.pop_front();
            end
        end
    end

    // ALU responder: checks operands at start, decides latency, predicts outcome
    initial begin : alu_model
        ops_t o;
        res_t e;
        int lat, guard;
        logic [7:0] pend_res;
        logic [3:0] pend_flg;
        logic [11:0] rf;
        alu_done = 1'b0;
        alu_result = 8'h00;
        alu_flags = 4'h0;
        guard = 0;
        pend_res = 8'h00;
        pend_flg = 4'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_res.delete();
                alu_cnt = 0;
                guard = 0;
            end else if (alu_start) begin
                check("in_ready_during_issue", {31'd0, in_ready}, 32'd0);
                if (exp_ops.size() == 0) begin
                    fail_now("unexpected_alu_start");
                end else begin
                    o = exp_ops.pop_front();
                    check("alu_a", {24'd0, alu_a}, {24'd0, o.a});
                    check("alu_b", {24'd0, alu_b}, {24'd0, o.b});
                    check("alu_op", {28'd0, alu_op}, {28'd0, o.op});
                    check("start_latency", cyc, o.start_cyc);
                end
                if (lat_q.size() > 0) lat = lat_q.pop_front();
                else begin
                    lat = $urandom_range(0, 21);
                    if (lat == 21) lat = TIMEOUT;
                end
                if (res_q.size() > 0) rf = res_q.pop_front();
                else rf = 12'($urandom);
                pend_res = rf[11:4];
                pend_flg = rf[3:0];
                if (lat >= 1 && lat <= TIMEOUT) begin
                    e.data = pend_res; e.flags = pend_flg; e.err = 1'b0; e.first_cyc = cyc + lat + 1;
                end else begin
                    e.data = 8'h00; e.flags = 4'h0; e.err = 1'b1; e.first_cyc = cyc + TIMEOUT + 1;
                end
                exp_res.push_back(e);
                alu_cnt = lat;
                guard = TIMEOUT + 4;
            end
            @(posedge clk);
            #1;
            alu_done = 1'b0;
            alu_result = 8'($urandom);
            alu_flags = 4'($urandom);
            if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    alu_done = 1'b1;
                    alu_result = pend_res;
                    alu_flags = pend_flg;
                end
            end else if (guard == 0 && $urandom_range(0, 7) == 0) begin
                alu_done = 1'b1;  // stray completion while no operation is outstanding
            end
            if (guard > 0) guard--;
        end
    end

    // Result monitor and out_ready driver
    initial begin : monitor
        bit first, handshake, seen_valid;
        int wait_cnt;
        res_t e;
        out_ready = 1'b0;
        first = 1'b1;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            handshake = 1'b0;
            seen_valid = 1'b0;
            if (rst) begin
                first = 1'b1;
            end else if (out_valid) begin
                seen_valid = 1'b1;
                check("in_ready_during_out", {31'd0, in_ready}, 32'd0);
                check("busy_during_out", {31'd0, busy}, 32'd1);
                if (exp_res.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    e = exp_res[0];
                    check("out_data", {24'd0, out_data}, {24'd0, e.data});
                    check("out_flags", {28'd0, out_flags}, {28'd0, e.flags});
                    check("out_err", {31'd0, out_err}, {31'd0, e.err});
                    if (first) begin
                        check("out_latency", cyc, e.first_cyc);
                        wait_cnt = (hold_q.size() > 0) ? hold_q.pop_front() : $urandom_range(0, 3);
                    end
                    first = 1'b0;
                    if (out_ready) begin
                        void'(exp_res.pop_front());
                        n_done++;
                        first = 1'b1;
                        handshake = 1'b1;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (ready_always) out_ready = 1'b1;
            else if (handshake || rst) out_ready = 1'b0;
            else if (seen_valid && !out_ready) begin
                if (wait_cnt > 0) wait_cnt--;
                else out_ready = 1'b1;
            end
        end
    end

    task automatic check_reset();
        check("rst_alu_a", {24'd0, alu_a}, 32'd0);
        check("rst_alu_b", {24'd0, alu_b}, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_alu_start", {31'd0, alu_start}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_flags", {28'd0, out_flags}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (stim_q.size() == 0 && !in_valid && exp_ops.size() == 0 && exp_res.size() == 0 &&
                alu_cnt == 0 && !busy && part.size() == 0)
                break;
        end
        if (i >= budget) fail_now("idle_wait_expired");
    endtask

    task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        stim_q.push_back(a);
        stim_q.push_back(b);
        stim_q.push_back(op);
    endtask

    initial begin : main
        int done_before, bytes_before, k;
        in_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #2 rst = 1'b0;

        // Directed: 12/34/01, ALU answers 46 after 3 cycles, consumer stalls
        gap_pct = 0;
        lat_q.push_back(3);
        res_q.push_back({8'h46, 4'h0});
        hold_q.push_back(4);
        push_op(8'h12, 8'h34, 8'h01);
        wait_idle(200);

        // Directed: no completion -> timeout error
        lat_q.push_back(0);
        push_op(8'hAB, 8'hCD, 8'hF7);
        wait_idle(200);

        // Directed: completion on the timeout cycle wins
        lat_q.push_back(TIMEOUT);
        res_q.push_back({8'hA5, 4'hC});
        push_op(8'h01, 8'h02, 8'h03);
        wait_idle(200);

        // Directed: reset after A and B loaded discards the partial operation
        push_op(8'h55, 8'h66, 8'h00);
        void'(stim_q.pop_back());
        for (k = 0; k < 100 && part.size() != 2; k++) begin
            @(posedge clk);
            #2;
        end
        if (k >= 100) fail_now("partial_load_wait_expired");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
        push_op(8'h77, 8'h88, 8'h93);
        wait_idle(200);

        // in_valid held high, consumer always ready: exactly 3 bytes per operation
        ready_always = 1'b1;
        done_before = n_done;
        bytes_before = n_bytes;
        for (int i = 0; i < 4; i++) push_op(8'($urandom), 8'($urandom), 8'($urandom));
        wait_idle(400);
        check("streamed_ops", n_done - done_before, 32'd4);
        check("streamed_bytes", n_bytes - bytes_before, 32'd12);
        ready_always = 1'b0;

        // Random traffic with gaps, random latencies and stalls
        gap_pct = 30;
        done_before = n_done;
        for (int i = 0; i < 40; i++) push_op(8'($urandom), 8'($urandom), 8'($urandom));
        wait_idle(4000);
        check("random_ops", n_done - done_before, 32'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles to wait for alu_done after issue (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  8  serial operand/opcode byte from the pin bus.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  sequencer accepts a byte this cycle.
REQ-007 alu_a, alu_b  output  8 each  operands driven to the downstream ALU.
REQ-008 alu_op  output  4  opcode driven to the ALU.
REQ-009 alu_start  output  1  one-cycle pulse requesting an ALU operation.
REQ-010 alu_result  input  8; alu_flags  input  4; alu_done  input  1  ALU response, sampled when alu_done=1.
REQ-011 out_data  output  8; out_flags  output  4; out_err  output  1  captured result, flags, timeout error.
REQ-012 out_valid  output  1; out_ready  input  1  result handshake to consumer.
REQ-013 busy  output  1  high in every state except LOAD_A.

Function
REQ-014 FSM states: LOAD_A, LOAD_B, LOAD_OP, ISSUE, WAIT, OUT; exactly one active.
REQ-015 Byte transfer occurs on a cycle with in_valid=1 and in_ready=1; in_ready=1 only in LOAD_A, LOAD_B, LOAD_OP.
REQ-016 LOAD_A: on transfer, alu_a <= in_data, go LOAD_B; otherwise hold.
REQ-017 LOAD_B: on transfer, alu_b <= in_data, go LOAD_OP.
REQ-018 LOAD_OP: on transfer, alu_op <= in_data[3:0] (in_data[7:4] ignored), go ISSUE.
REQ-019 ISSUE: alu_start=1 for exactly this one cycle, clear timeout counter, go WAIT.
REQ-020 alu_a/alu_b/alu_op remain stable from load until the next transfer into the same register.
REQ-021 WAIT: counter increments each cycle; alu_done=1 -> capture alu_result/alu_flags into out_data/out_flags, out_err<=0, go OUT.
REQ-022 WAIT: counter reaching TIMEOUT with alu_done=0 -> out_data<=8'h00, out_flags<=4'h0, out_err<=1, go OUT.
REQ-023 alu_done and timeout in same cycle: alu_done wins, out_err=0.
REQ-024 alu_done outside WAIT is ignored.
REQ-025 OUT: out_valid=1; out_data/out_flags/out_err held stable until out_ready=1; transfer -> LOAD_A next cycle.
REQ-026 Latency: last byte accepted at edge N -> alu_start high cycle N+1; alu_done at cycle M -> out_valid high from M+1.
REQ-027 in_valid while in ISSUE/WAIT/OUT is not consumed (in_ready=0); upstream must hold the byte.
REQ-028 Minimum operation: 3 transfer cycles + ISSUE + >=1 WAIT + OUT = 6 cycles back-to-back.

Reset
REQ-029 rst=1 at a rising edge forces LOAD_A regardless of state, including mid-load and WAIT.
REQ-030 Reset values: alu_a=alu_b=8'h00, alu_op=4'h0, alu_start=0, out_data=8'h00, out_flags=4'h0, out_err=0, out_valid=0, busy=0, counter=0; in_ready=1 in first cycle after reset release.
REQ-031 Partial loads and pending results are discarded by reset; no alu_start emitted for them.

Verification
REQ-032 Bytes 8'h12, 8'h34, 8'h01 on consecutive cycles -> alu_a=8'h12, alu_b=8'h34, alu_op=4'h1, single alu_start pulse next cycle.
REQ-033 Model alu_done 3 cycles after start with result 8'h46, flags 4'b0000 -> out_valid=1, out_data=8'h46, out_err=0; held while out_ready=0 for 5 cycles.
REQ-034 No alu_done after start -> after TIMEOUT=16 WAIT cycles out_valid=1, out_err=1, out_data=8'h00.
REQ-035 alu_done coincident with the timeout cycle -> out_err=0, captured result reported.
REQ-036 rst asserted after A and B loaded -> LOAD_A, all outputs at reset values; new 3-byte sequence processes normally.
REQ-037 in_valid held high throughout with out_ready=1 -> exactly 3 bytes consumed per operation, in_ready=0 during ISSUE/WAIT/OUT.
